// File: rtl/ram_based_shift_reg.sv
// Fixed-length delay line built on an inferred RAM circular buffer.
// Each sample written into the buffer appears on registered Q exactly WDEPTH clocks later.
module ram_based_shift_reg #(
  parameter int DSIZE  = 6,
  parameter int WDEPTH = 10
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [DSIZE-1:0] Din,
  output logic [DSIZE-1:0] Q
);

  localparam int ASIZE = $clog2(WDEPTH);
  localparam int FSIZE = $clog2(WDEPTH + 1);
  localparam logic [ASIZE-1:0] PTR_LAST  = ASIZE'(WDEPTH - 1);
  localparam logic [FSIZE-1:0] FILL_FULL = FSIZE'(WDEPTH);

  logic [DSIZE-1:0] mem [WDEPTH];
  logic [ASIZE-1:0] ptr;
  logic [FSIZE-1:0] fill;

  // NOTE: the array has no reset so it maps onto block/distributed RAM; stale
  // words are hidden by the fill counter instead of being cleared.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      mem[ptr] <= Din;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      ptr  <= '0;
      fill <= '0;
      Q    <= '0;
    end else begin
      // NOTE: non-blocking assignment means this read sees the word from before
      // this edge's write, which gives the required read-before-write behaviour.
      Q    <= (fill == FILL_FULL) ? mem[ptr] : '0;
      ptr  <= (ptr == PTR_LAST) ? '0 : ptr + ASIZE'(1);
      if (fill != FILL_FULL) begin
        fill <= fill + FSIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_based_shift_reg.sv
// Bench for ram_based_shift_reg: three depths (10, 16, 3) share one clock and reset,
// checked every cycle against per-instance sample-history queues.
module tb_ram_based_shift_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] din10 = '0;
  logic [7:0] din16 = '0;
  logic [5:0] din3  = '0;
  logic [5:0] q10;
  logic [7:0] q16;
  logic [5:0] q3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_based_shift_reg #(.DSIZE(6), .WDEPTH(10)) u10 (
    .clk(clk), .Reset(reset), .Din(din10), .Q(q10));
  ram_based_shift_reg #(.DSIZE(8), .WDEPTH(16)) u16 (
    .clk(clk), .Reset(reset), .Din(din16), .Q(q16));
  ram_based_shift_reg #(.DSIZE(6), .WDEPTH(3)) u3 (
    .clk(clk), .Reset(reset), .Din(din3), .Q(q3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: the samples accepted since the last reset edge, oldest first.
  // A sample leaves (and is expected on Q) once WDEPTH newer edges have passed.
  logic [5:0] h10[$];
  logic [7:0] h16[$];
  logic [5:0] h3[$];
  logic [5:0] e10, e3;
  logic [7:0] e16;
  bit started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      h10.delete(); h16.delete(); h3.delete();
      e10 = '0; e16 = '0; e3 = '0;
      started = 1'b1;
    end else begin
      h10.push_back(din10);
      h16.push_back(din16);
      h3.push_back(din3);
      e10 = (h10.size() > 10) ? h10.pop_front() : '0;
      e16 = (h16.size() > 16) ? h16.pop_front() : '0;
      e3  = (h3.size()  > 3)  ? h3.pop_front()  : '0;
    end
    #1;
    if (started) begin
      check("q10_model", 32'(q10), 32'(e10));
      check("q16_model", 32'(q16), 32'(e16));
      check("q3_model",  32'(q3),  32'(e3));
    end
  end

  bit rand3 = 1'b1;

  // One clock edge: inputs change on the falling edge, return 2 time units after the rising edge.
  task automatic step(input logic r, input logic [5:0] d);
    @(negedge clk);
    reset = r;
    din10 = d;
    din16 = 8'($urandom);
    din3  = rand3 ? 6'($urandom) : d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held 10 cycles with Din all ones.
    for (int i = 0; i < 10; i++) step(1'b1, 6'h3F);
    check("reset_hold_q10", 32'(q10), 32'h0);

    // Incrementing stream, run past 64 samples to see the data wrap.
    rand3 = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step(1'b0, 6'(k));
      if (k == 2)  check("w3_fill_end", 32'(q3), 32'h0);
      if (k == 5)  check("w3_delay", 32'(q3), 32'h2);
      if (k == 9)  check("fill_last_edge", 32'(q10), 32'h0);
      if (k == 10) check("first_out", 32'(q10), 32'h0);
      if (k == 15) check("delay_10", 32'(q10), 32'h5);
      if (k == 73) check("pre_wrap", 32'(q10), 32'h3F);
      if (k == 74) check("wrap_zero", 32'(q10), 32'h0);
      if (k == 75) check("post_wrap", 32'(q10), 32'h1);
    end
    rand3 = 1'b1;
    for (int k = 80; k < 300; k++) step(1'b0, 6'(k));
    check("steady_300", 32'(q10), 32'((299 - 10) % 64));

    // Long reset after running: RAM now holds stale non-zero words.
    step(1'b1, 6'h3F);
    check("reset_edge_q10", 32'(q10), 32'h0);
    for (int i = 1; i < 10; i++) step(1'b1, 6'h3F);
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 6'(k));
      if (k == 9)  check("stale_hidden", 32'(q10), 32'h0);
      if (k == 11) check("restart_stream", 32'(q10), 32'h1);
    end

    // Single-cycle reset pulse: its Din is dropped and the fill period restarts.
    step(1'b1, 6'h2A);
    for (int k = 0; k < 25; k++) begin
      step(1'b0, 6'(k + 32));
      if (k == 9)  check("pulse_fill", 32'(q10), 32'h0);
      if (k == 10) check("pulse_first", 32'(q10), 32'd32);
      if (k == 14) check("pulse_delay", 32'(q10), 32'd36);
    end

    // Random stream on all instances after a short reset.
    step(1'b1, 6'h00);
    for (int k = 0; k < 60; k++) step(1'b0, 6'($urandom));

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_based_shift_reg.md
Name: ram_based_shift_reg

Overview:
Fixed-length delay line (shift register) built from an inferred RAM circular buffer, not a flip-flop chain. Each clock, one DSIZE-bit sample enters and the sample written WDEPTH clocks earlier leaves on a registered output. It is used inside the Kyber datapath wherever a deep, wide pipeline delay is needed cheaply. The block has no dependency on any global set/reset primitive; all initialisation comes from its own Reset.

Parameters:
DSIZE, 6, data width in bits of Din/Q.
WDEPTH, 10, delay length in clock cycles (RAM word count); legal range 2..1024, non-power-of-2 allowed.
ASIZE (localparam), $clog2(WDEPTH), address/pointer width.

Ports:
clk  input  1  single clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Din  input  DSIZE  sample shifted in every clock.
Q  output  DSIZE  delayed sample, registered.

Behaviour:
- One clock; Reset is synchronous and active-high. No clock enable: the register shifts on every clk edge with Reset low.
- State: RAM mem[0..WDEPTH-1] of DSIZE bits; write/read pointer ptr (ASIZE bits); fill counter fill (0..WDEPTH, saturating); output register Q.
- Reset edge: ptr <= 0, fill <= 0, Q <= 0. RAM contents are not cleared. Din is ignored (not written) on a reset edge.
- Normal edge (Reset low), all in parallel:
  - Q <= (fill == WDEPTH) ? mem[ptr] : 0 (read-before-write, old contents).
  - mem[ptr] <= Din.
  - ptr <= (ptr == WDEPTH-1) ? 0 : ptr+1 (explicit wrap, not modulo 2^ASIZE).
  - fill <= min(fill+1, WDEPTH).
- Latency: Din sampled at the k-th non-reset edge after reset (k = 0,1,...) appears on Q right after edge k+WDEPTH and holds for one cycle.
- Steady state: Q(n) = Din sampled at edge n-WDEPTH, exact bit copy with no arithmetic.
- Fill period: for the first WDEPTH non-reset edges after reset, Q stays 0 regardless of stale RAM data.
- Reset mid-operation: the in-flight samples are discarded. Q = 0 from the reset edge until WDEPTH non-reset edges have passed, then the post-reset stream resumes.
- Reset held several cycles: state stays at its reset values.
- RAM must infer as block or distributed RAM: one synchronous write port and one read port at the same address. Read-before-write semantics are required.

Test Plan:
- Reset held 10 cycles with Din = 0x3F -> Q = 0 throughout; Q = 0 for the first 10 edges after release.
- Reset release, then Din = 0,1,2,... incrementing each clock (DSIZE = 6) -> Q = 0 for 10 edges, then Q = 0,1,2,... i.e. Q = (Din - 10) mod 64 every cycle.
- Run past 64 samples -> Q wraps 63 -> 0 cleanly, still exactly 10 cycles behind Din; ptr wraps 9 -> 0 with no glitch or skipped sample.
- Reset pulsed for 10 cycles after about 300 cycles of running -> Q = 0 at the reset edge and for 10 edges after release, even though the RAM holds non-zero stale data. Then Q = post-reset Din sequence (0,1,...) delayed 10.
- Single-cycle Reset pulse mid-stream -> exactly one Din sample is dropped; the fill period of 10 cycles restarts.
- Random Din with WDEPTH = 16 and WDEPTH = 3 -> Q matches a 16- or 3-deep reference FIFO model bit-for-bit after fill.
